pc_gen: RTL and testbench

Parametrised program-counter generator for the IF stage; successor to the single-source PC register. Selects the next fetch address from a prediction input and N prioritised redirect sources, and holds the PC during I-/D-cache stalls. Captures redirects that arrive while stalled and applies them on the next advance. Drives the I-cache request.

---
 rtl/pc_gen.sv | 189 ++++++++++++++++++
 tb/tb_pc_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program-counter generator.
// Picks the next fetch address from N prioritised redirect sources, a
// redirect captured during a stall, or the branch prediction. It holds the
// PC while either cache stalls and drives the I-cache request.
// Optional build macro PC_PERF_CNT_EN adds saturating stall and redirect
// counters (stall_cnt_o, redir_cnt_o).
//
//   state  | meaning
//   BOOT   | out of reset, waiting for the first advance to fetch RESET_VEC
//   RUN    | fetching; PC follows the selected target every advance
//   HOLD   | stalled, no redirect captured
//   HOLD_R | stalled with a captured redirect waiting to be applied
module pc_gen #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(32'h1000_0000),
    parameter int                INSTR_BYTES = 4,
    parameter int                REDIR_N     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           pred_pc_i,
    input  logic [REDIR_N-1:0]          redir_valid_i,
    input  logic [REDIR_N*ADDR_W-1:0]   redir_pc_i,
    input  logic                        istall,
    input  logic                        dstall,
    input  logic                        fetch_ready_i,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        fetch_req_o,
    output logic                        flush_o,
`ifdef PC_PERF_CNT_EN
    output logic [31:0]                 stall_cnt_o,
    output logic [31:0]                 redir_cnt_o,
`endif
    output logic                        pend_o
);

    // Index width must also encode REDIR_N, used as "no pending source".
    localparam int                IDX_W      = $clog2(REDIR_N + 1);
    localparam logic [IDX_W-1:0]  IDX_NONE   = IDX_W'(REDIR_N);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] PC_RST     = RESET_VEC - ADDR_W'(INSTR_BYTES);

    typedef enum logic [1:0] {BOOT, RUN, HOLD, HOLD_R} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               fetch_req_q, fetch_req_d;
    logic               flush_q, flush_d;
    logic               pend_q, pend_d;
    logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;

    logic               advance;
    logic               any_redir;
    logic [IDX_W-1:0]   sel_idx;
    logic [ADDR_W-1:0]  sel_pc;
    logic [ADDR_W-1:0]  target;

    assign advance   = !istall && !dstall && fetch_ready_i;
    assign any_redir = |redir_valid_i;

    // Priority encode: lowest-index valid redirect source wins.
    always_comb begin
        sel_idx = IDX_NONE;
        sel_pc  = '0;
        for (int k = REDIR_N - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                sel_idx = IDX_W'(k);
                sel_pc  = redir_pc_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Target order: live redirect, then captured redirect, then prediction.
    always_comb begin
        if (any_redir)   target = sel_pc;
        else if (pend_q) target = pend_pc_q;
        else             target = pred_pc_i;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_req_d = 1'b0;
        flush_d     = 1'b0;
        pend_d      = pend_q;
        pend_pc_d   = pend_pc_q;
        pend_idx_d  = pend_idx_q;
        case (state_q)
            BOOT: begin
                if (advance) begin
                    pc_d        = RESET_VEC;
                    fetch_req_d = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN, HOLD: begin
                if (advance) begin
                    pc_d        = target & ALIGN_MASK;
                    fetch_req_d = 1'b1;
                    flush_d     = any_redir;
                    state_d     = RUN;
                end else if (any_redir) begin
                    pend_d     = 1'b1;
                    pend_pc_d  = sel_pc;
                    pend_idx_d = sel_idx;
                    flush_d    = 1'b1;
                    state_d    = HOLD_R;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD_R: begin
                if (advance) begin
                    pc_d        = target & ALIGN_MASK;
                    fetch_req_d = 1'b1;
                    flush_d     = any_redir;
                    pend_d      = 1'b0;
                    pend_idx_d  = IDX_NONE;
                    state_d     = RUN;
                end else if (any_redir && (sel_idx <= pend_idx_q)) begin
                    // Equal-or-higher priority replaces the captured one;
                    // lower priority is dropped silently (no flush).
                    pend_pc_d  = sel_pc;
                    pend_idx_d = sel_idx;
                    flush_d    = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= PC_RST;
            fetch_req_q <= 1'b0;
            flush_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            pend_idx_q  <= IDX_NONE;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_req_q <= fetch_req_d;
            flush_q     <= flush_d;
            pend_q      <= pend_d;
            pend_pc_q   <= pend_pc_d;
            pend_idx_q  <= pend_idx_d;
        end
    end

    assign pc_o        = pc_q;
    assign fetch_req_o = fetch_req_q;
    assign flush_o     = flush_q;
    assign pend_o      = pend_q;

`ifdef PC_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    // Saturating counters: stalled post-boot cycles and flush pulses.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if ((state_q != BOOT) && !advance && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush_q && (redir_cnt_q != 32'hFFFF_FFFF))
            redir_cnt_d = redir_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign redir_cnt_o = redir_cnt_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed vector table, hand-written reset/boot
// sequence, then randomized stimulus against a behavioural model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic [2:0]  redir_valid;
    logic [95:0] redir_pc;
    logic        istall, dstall, fetch_ready;
    logic [31:0] pc;
    logic        fetch_req, flush, pend;
`ifdef PC_PERF_CNT_EN
    logic [31:0] stall_cnt, redir_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .pred_pc_i     (pred_pc),
        .redir_valid_i (redir_valid),
        .redir_pc_i    (redir_pc),
        .istall        (istall),
        .dstall        (dstall),
        .fetch_ready_i (fetch_ready),
        .pc_o          (pc),
        .fetch_req_o   (fetch_req),
        .flush_o       (flush),
`ifdef PC_PERF_CNT_EN
        .stall_cnt_o   (stall_cnt),
        .redir_cnt_o   (redir_cnt),
`endif
        .pend_o        (pend)
    );

    // Behavioural model: "booted" flag plus an optional captured redirect.
    logic        m_booted;
    logic [31:0] m_pc;
    logic        m_req, m_flush, m_pend;
    logic [31:0] m_pend_pc;
    int          m_pend_prio;
    logic [31:0] m_stall_cnt, m_redir_cnt;

    task automatic model_step();
        bit adv;
        int sel;
        logic [31:0] tgt;
        adv = !istall && !dstall && fetch_ready;
        sel = -1;
        for (int k = 2; k >= 0; k--) if (redir_valid[k]) sel = k;
        if (rst) begin
            m_booted = 0; m_pc = 32'h0FFF_FFFC; m_req = 0; m_flush = 0;
            m_pend = 0; m_pend_prio = 3; m_stall_cnt = 0; m_redir_cnt = 0;
            return;
        end
        if (m_booted && !adv) m_stall_cnt++;
        if (m_flush) m_redir_cnt++;
        if (!m_booted) begin
            m_flush = 0;
            m_req   = adv;
            if (adv) begin m_pc = 32'h1000_0000; m_booted = 1; end
        end else if (adv) begin
            if (sel >= 0)    tgt = redir_pc[sel*32 +: 32];
            else if (m_pend) tgt = m_pend_pc;
            else             tgt = pred_pc;
            m_pc    = {tgt[31:2], 2'b00};
            m_flush = (sel >= 0);
            m_pend  = 0;
            m_pend_prio = 3;
            m_req   = 1;
        end else begin
            m_req   = 0;
            m_flush = 0;
            if (sel >= 0 && (!m_pend || sel <= m_pend_prio)) begin
                m_pend = 1; m_pend_pc = redir_pc[sel*32 +: 32];
                m_pend_prio = sel; m_flush = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, update model, sample at +1.
    task automatic cyc(input logic r, input logic is, input logic ds, input logic rd,
                       input logic [2:0] rv, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] p2, input logic [31:0] pd);
        rst = r; istall = is; dstall = ds; fetch_ready = rd;
        redir_valid = rv; redir_pc = {p2, p1, p0}; pred_pc = pd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic e_req,
                           input logic e_fl, input logic e_pend);
        chk({tag, ".pc"},    pc,                 e_pc);
        chk({tag, ".req"},   {31'd0, fetch_req}, {31'd0, e_req});
        chk({tag, ".flush"}, {31'd0, flush},     {31'd0, e_fl});
        chk({tag, ".pend"},  {31'd0, pend},      {31'd0, e_pend});
    endtask

    typedef struct {
        logic        r, is, ds, rd;
        logic [2:0]  rv;
        logic [31:0] p0, p1, p2, pd;
        logic [31:0] e_pc;
        logic        e_req, e_fl, e_pend;
    } vec_t;

    function automatic vec_t v(logic r, logic is, logic ds, logic rd, logic [2:0] rv,
                               logic [31:0] p0, logic [31:0] p1, logic [31:0] p2,
                               logic [31:0] pd, logic [31:0] e_pc, logic e_req,
                               logic e_fl, logic e_pend);
        vec_t x;
        x.r = r; x.is = is; x.ds = ds; x.rd = rd; x.rv = rv;
        x.p0 = p0; x.p1 = p1; x.p2 = p2; x.pd = pd;
        x.e_pc = e_pc; x.e_req = e_req; x.e_fl = e_fl; x.e_pend = e_pend;
        return x;
    endfunction

    vec_t vq[$];

    initial begin
        //                r is ds rd rv      p0        p1        p2        pred           pc           req fl pd
        vq.push_back(v(1, 0, 0, 1, 3'b000, 0,        0,        0,        32'h1000_0004, 32'h0FFF_FFFC, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 1, 3'b000, 0,        0,        0,        32'h1000_0004, 32'h1000_0000, 1, 0, 0));
        vq.push_back(v(0, 0, 0, 1, 3'b000, 0,        0,        0,        32'h1000_0004, 32'h1000_0004, 1, 0, 0));
        vq.push_back(v(0, 0, 0, 1, 3'b110, 0,        32'h2000, 32'h3000, 32'h1000_0008, 32'h0000_2000, 1, 1, 0));
        vq.push_back(v(0, 0, 0, 1, 3'b000, 0,        0,        0,        32'h0000_2004, 32'h0000_2004, 1, 0, 0));
        vq.push_back(v(0, 1, 0, 1, 3'b100, 0,        0,        32'h3000, 32'h0000_5000, 32'h0000_2004, 0, 1, 1));
        vq.push_back(v(0, 1, 0, 1, 3'b000, 0,        0,        0,        32'h0000_5000, 32'h0000_2004, 0, 0, 1));
        vq.push_back(v(0, 1, 0, 1, 3'b000, 0,        0,        0,        32'h0000_5000, 32'h0000_2004, 0, 0, 1));
        vq.push_back(v(0, 0, 0, 1, 3'b000, 0,        0,        0,        32'h0000_5000, 32'h0000_3000, 1, 0, 0));
        vq.push_back(v(0, 0, 1, 1, 3'b010, 0,        32'h2000, 0,        32'h0000_5000, 32'h0000_3000, 0, 1, 1));
        vq.push_back(v(0, 0, 1, 1, 3'b100, 0,        0,        32'h3000, 32'h0000_5000, 32'h0000_3000, 0, 0, 1));
        vq.push_back(v(0, 0, 1, 1, 3'b001, 32'h4000, 0,        0,        32'h0000_5000, 32'h0000_3000, 0, 1, 1));
        vq.push_back(v(0, 0, 0, 1, 3'b000, 0,        0,        0,        32'h0000_5000, 32'h0000_4000, 1, 0, 0));
        vq.push_back(v(0, 0, 0, 1, 3'b000, 0,        0,        0,        32'h1000_0007, 32'h1000_0004, 1, 0, 0));
        vq.push_back(v(0, 0, 0, 1, 3'b000, 0,        0,        0,        32'hFFFF_FFFF, 32'hFFFF_FFFC, 1, 0, 0));
        vq.push_back(v(0, 0, 0, 0, 3'b000, 0,        0,        0,        32'h0000_0010, 32'hFFFF_FFFC, 0, 0, 0));
        vq.push_back(v(0, 0, 0, 1, 3'b000, 0,        0,        0,        32'h0000_0008, 32'h0000_0008, 1, 0, 0));

        cyc(1, 0, 0, 1, 3'b000, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 3'b000, 0, 0, 0, 0);
        chk_out("reset", 32'h0FFF_FFFC, 0, 0, 0);

        foreach (vq[i]) begin
            cyc(vq[i].r, vq[i].is, vq[i].ds, vq[i].rd, vq[i].rv,
                vq[i].p0, vq[i].p1, vq[i].p2, vq[i].pd);
            chk_out($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_req, vq[i].e_fl, vq[i].e_pend);
        end
`ifdef PC_PERF_CNT_EN
        chk("vec.stall_cnt", stall_cnt, 32'd7);
        chk("vec.redir_cnt", redir_cnt, 32'd4);
`endif

        // Reset while a redirect is pending, stalled boot, redirect ignored in BOOT.
        cyc(0, 1, 0, 1, 3'b001, 32'h0000_ABC0, 0, 0, 32'h0000_9000);
        chk_out("capture", 32'h0000_0008, 0, 1, 1);
        cyc(1, 1, 0, 1, 3'b000, 0, 0, 0, 32'h0000_9000);
        chk_out("rst_pend", 32'h0FFF_FFFC, 0, 0, 0);
`ifdef PC_PERF_CNT_EN
        chk("rst.stall_cnt", stall_cnt, 32'd0);
        chk("rst.redir_cnt", redir_cnt, 32'd0);
`endif
        cyc(0, 1, 0, 1, 3'b000, 0, 0, 0, 32'h0000_9000);
        chk_out("boot_stall", 32'h0FFF_FFFC, 0, 0, 0);
`ifdef PC_PERF_CNT_EN
        chk("boot.stall_cnt", stall_cnt, 32'd0);
`endif
        cyc(0, 0, 0, 1, 3'b001, 32'h0000_7770, 0, 0, 32'h0000_5550);
        chk_out("boot_redir", 32'h1000_0000, 1, 0, 0);
        cyc(0, 0, 0, 1, 3'b000, 0, 0, 0, 32'h1000_0010);
        chk_out("after_boot", 32'h1000_0010, 1, 0, 0);
        cyc(0, 0, 1, 1, 3'b000, 0, 0, 0, 32'h1000_0020);
`ifdef PC_PERF_CNT_EN
        chk("stall1.stall_cnt", stall_cnt, 32'd1);
`endif

        // Randomized run checked against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0]  rv;
            logic [31:0] a0, a1, a2, pd;
            rv[0] = ($urandom_range(0, 9) == 0);
            rv[1] = ($urandom_range(0, 6) == 0);
            rv[2] = ($urandom_range(0, 4) == 0);
            a0 = $urandom; a1 = $urandom; a2 = $urandom;
            pd = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : $urandom;
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) != 0),
                rv, a0, a1, a2, pd);
            chk_out("rand", m_pc, m_req, m_flush, m_pend);
`ifdef PC_PERF_CNT_EN
            chk("rand.stall_cnt", stall_cnt, m_stall_cnt);
            chk("rand.redir_cnt", redir_cnt, m_redir_cnt);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
